// File: rtl/round_key_adder.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion.
// The block XORs plaintext with the cipher key, then sends each round state
// to the SubBytes/ShiftRows/MixColumns path. It adds the next round key to
// each returning state. After round 10 it presents the ciphertext.
// Optional build macro: AES_ROUND_KEY_EXPORT_EN adds a roundKey output
// that mirrors the current round key register.

// AES forward S-box. The table is stored MSB-first, so entry 0 occupies the
// top byte of the table.
module sBox (
  input  logic [7:0] inByte,
  output logic [7:0] outByte
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry idx starts at bit 8*(255-idx). 255-idx is the same as ~idx.
  logic [10:0] bitPos;

  assign bitPos  = {~inByte, 3'b000};
  assign outByte = SBOX_TABLE[bitPos +: 8];
endmodule

module round_key_adder (
  input  logic         clk,
  input  logic         reset,
  input  logic         startValid,
  output logic         startReady,
  input  logic [127:0] plainText,
  input  logic [127:0] cipherKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] outState,
  output logic [3:0]   roundNum,
  input  logic         feedbackValid,
  input  logic [127:0] feedbackState,
  output logic         cipherValid,
  input  logic         cipherReady,
  output logic [127:0] cipherText
`ifdef AES_ROUND_KEY_EXPORT_EN
  ,
  output logic [127:0] roundKey
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT    = 2'd1,
    WAIT_FB = 2'd2,
    DONE    = 2'd3
  } stateT;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  stateT        state;
  stateT        stateNext;
  logic [127:0] stateReg;
  logic [127:0] keyReg;
  logic [3:0]   round;

  logic         loadStart;
  logic         advanceRound;
  logic         loadFeedback;

  // rcon for the key that comes after round r, so r=0 gives the round-1 constant.
  function automatic logic [7:0] rconAfter(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Next round key. Word 0 is the most significant word of keyReg.
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rotW;
  logic [31:0] subW;
  logic [31:0] n0, n1, n2, n3;
  logic [127:0] nextKey;

  assign w0   = keyReg[127:96];
  assign w1   = keyReg[95:64];
  assign w2   = keyReg[63:32];
  assign w3   = keyReg[31:0];
  assign rotW = {w3[23:0], w3[31:24]};

  sBox sBox3 (.inByte(rotW[31:24]), .outByte(subW[31:24]));
  sBox sBox2 (.inByte(rotW[23:16]), .outByte(subW[23:16]));
  sBox sBox1 (.inByte(rotW[15:8]),  .outByte(subW[15:8]));
  sBox sBox0 (.inByte(rotW[7:0]),   .outByte(subW[7:0]));

  assign n0      = w0 ^ subW ^ {rconAfter(round), 24'h000000};
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign nextKey = {n0, n1, n2, n3};

  // FSM state register; reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic, handshake outputs and datapath load strobes.
  always_comb begin
    stateNext    = state;
    startReady   = 1'b0;
    outValid     = 1'b0;
    cipherValid  = 1'b0;
    loadStart    = 1'b0;
    advanceRound = 1'b0;
    loadFeedback = 1'b0;
    case (state)
      IDLE: begin
        startReady = 1'b1;
        if (startValid) begin
          loadStart = 1'b1;
          stateNext = EMIT;
        end
      end
      EMIT: begin
        outValid = 1'b1;
        // This guard keeps round from wrapping past 10, even if state is corrupted.
        if (outReady && (round < LAST_ROUND)) begin
          advanceRound = 1'b1;
          stateNext    = WAIT_FB;
        end
      end
      WAIT_FB: begin
        if (feedbackValid) begin
          loadFeedback = 1'b1;
          stateNext    = (round == LAST_ROUND) ? DONE : EMIT;
        end
      end
      DONE: begin
        cipherValid = 1'b1;
        if (cipherReady) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Round state, round key and round counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= '0;
      keyReg   <= '0;
      round    <= '0;
    end else if (loadStart) begin
      stateReg <= plainText ^ cipherKey;
      keyReg   <= cipherKey;
      round    <= '0;
    end else if (advanceRound) begin
      keyReg   <= nextKey;
      round    <= round + 4'd1;
    end else if (loadFeedback) begin
      stateReg <= feedbackState ^ keyReg;
    end
  end

  assign outState   = stateReg;
  assign roundNum   = round;
  assign cipherText = stateReg;

`ifdef AES_ROUND_KEY_EXPORT_EN
  assign roundKey = keyReg;
`else
  // The round key stays internal when the export macro is not defined.
`endif

endmodule

// File: tb/tb_round_key_adder.sv
// Scoreboard bench for round_key_adder. It contains a full AES-128 reference
// model whose S-box comes from GF(2^8) inversion plus the affine map.
// Optional build macro: AES_ROUND_KEY_EXPORT_EN also checks the roundKey port.
module tb_round_key_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         startValid;
  logic         startReady;
  logic [127:0] plainText;
  logic [127:0] cipherKey;
  logic         outValid;
  logic         outReady;
  logic [127:0] outState;
  logic [3:0]   roundNum;
  logic         feedbackValid;
  logic [127:0] feedbackState;
  logic         cipherValid;
  logic         cipherReady;
  logic [127:0] cipherText;
`ifdef AES_ROUND_KEY_EXPORT_EN
  logic [127:0] roundKey;
`endif

  round_key_adder dut (
    .clk(clk),
    .reset(reset),
    .startValid(startValid),
    .startReady(startReady),
    .plainText(plainText),
    .cipherKey(cipherKey),
    .outValid(outValid),
    .outReady(outReady),
    .outState(outState),
    .roundNum(roundNum),
    .feedbackValid(feedbackValid),
    .feedbackState(feedbackState),
    .cipherValid(cipherValid),
    .cipherReady(cipherReady),
    .cipherText(cipherText)
`ifdef AES_ROUND_KEY_EXPORT_EN
    ,
    .roundKey(roundKey)
`endif
  );

  localparam logic [127:0] C1_KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_ROUND0 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1_CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] APPX_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] APPX_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] APPX_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    bit           isCipher;
    logic [3:0]   rnd;
    logic [127:0] data;
  } expT;

  expT          sbQ[$];
  int           nChecks = 0;
  int           nPass   = 0;
  logic [7:0]   sboxT[256];
  logic [127:0] rkM[11];
  logic [127:0] expS[10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] getB(input logic [127:0] x, input int i);
    return x[127 - 8*i -: 8];
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = sboxT[getB(s, i)];
    return o;
  endfunction

  // Byte i is row i%4, column i/4; row r rotates left by r columns.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = getB(s, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = getB(s, 4*c); a1 = getB(s, 4*c+1); a2 = getB(s, 4*c+2); a3 = getB(s, 4*c+3);
      o[127 - 8*(4*c)   -: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      o[127 - 8*(4*c+1) -: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      o[127 - 8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      o[127 - 8*(4*c+3) -: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return o;
  endfunction

  // The external round path: round 9 leaves out MixColumns.
  function automatic logic [127:0] roundFn(input logic [127:0] s, input int r);
    if (r < 9) return mixColumns(shiftRows(subBytes(s)));
    return shiftRows(subBytes(s));
  endfunction

  task automatic expandKey(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rkM[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
  endtask

  // Queue every response expected from one encryption.
  task automatic pushExpected(input logic [127:0] pt, input logic [127:0] key,
                              input bit useConst, input logic [127:0] exp0, input logic [127:0] expC);
    logic [127:0] s;
    expT e;
    expandKey(key);
    s = pt ^ rkM[0];
    for (int r = 0; r < 10; r++) begin
      if (r > 0) s = mixColumns(shiftRows(subBytes(s))) ^ rkM[r];
      expS[r] = (useConst && r == 0) ? exp0 : s;
      e.isCipher = 1'b0; e.rnd = 4'(r); e.data = expS[r];
      sbQ.push_back(e);
    end
    s = shiftRows(subBytes(s)) ^ rkM[10];
    e.isCipher = 1'b1; e.rnd = 4'd0; e.data = useConst ? expC : s;
    sbQ.push_back(e);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    expT e;
    if (!reset) begin
      if (outValid || cipherValid)
        check("valid_exclusive", {127'b0, outValid & cipherValid}, 128'd0);
      if (outValid && outReady) begin
        if (sbQ.size() == 0) check("sb_underflow_out", 128'd1, 128'd0);
        else begin
          e = sbQ.pop_front();
          check("out_kind", {127'b0, e.isCipher}, 128'd0);
          check("outState", outState, e.data);
          check("roundNum", {124'b0, roundNum}, {124'b0, e.rnd});
        end
      end
      if (cipherValid && cipherReady) begin
        if (sbQ.size() == 0) check("sb_underflow_ct", 128'd1, 128'd0);
        else begin
          e = sbQ.pop_front();
          check("ct_kind", {127'b0, e.isCipher}, 128'd1);
          check("cipherText", cipherText, e.data);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runEnc(input logic [127:0] pt, input logic [127:0] key, input int stallRound,
                        input int abortRound, input bit strayAtStart, input bit useConst,
                        input logic [127:0] exp0, input logic [127:0] expC);
    logic [127:0] cap;
    int t;
    pushExpected(pt, key, useConst, exp0, expC);
    t = 0;
    while (!startReady && t < 20) begin tick(); t++; end
    check("startReady_wait", {127'b0, startReady}, 128'd1);
    startValid = 1'b1; plainText = pt; cipherKey = key;
    feedbackValid = strayAtStart; feedbackState = {$urandom, $urandom, $urandom, $urandom};
    tick();
    startValid = 1'b0; feedbackValid = 1'b0;
    check("start_latency", {127'b0, outValid}, 128'd1);
    for (int r = 0; r < 10; r++) begin
      if (r == stallRound) begin
        for (int k = 0; k < 5; k++) begin
          startValid = 1'b1; feedbackValid = 1'b1;
          feedbackState = {$urandom, $urandom, $urandom, $urandom};
          plainText = {$urandom, $urandom, $urandom, $urandom};
          tick();
          check("stall_outState", outState, expS[r]);
          check("stall_roundNum", {124'b0, roundNum}, 128'(r));
          check("stall_startReady", {127'b0, startReady}, 128'd0);
        end
        startValid = 1'b0; feedbackValid = 1'b0;
      end
      cap = outState;
      outReady = 1'b1;
      tick();
      outReady = 1'b0;
`ifdef AES_ROUND_KEY_EXPORT_EN
      if (r == 0) check("roundKey_r1", roundKey, (key == APPX_KEY) ? APPX_RK1 : rkM[1]);
      if (r == 9) check("roundKey_r10", roundKey, (key == APPX_KEY) ? APPX_RK10 : rkM[10]);
`endif
      check("wait_fb_no_out", {127'b0, outValid}, 128'd0);
      if (r == abortRound) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_startReady", {127'b0, startReady}, 128'd1);
        check("rst_outValid", {127'b0, outValid}, 128'd0);
        check("rst_cipherValid", {127'b0, cipherValid}, 128'd0);
        sbQ.delete();
        return;
      end
      repeat ($urandom_range(0, 2)) tick();
      feedbackValid = 1'b1;
      feedbackState = roundFn(cap, r);
      tick();
      feedbackValid = 1'b0;
      if (r < 9) check("fb_latency_out", {127'b0, outValid}, 128'd1);
      else       check("fb_latency_ct", {127'b0, cipherValid}, 128'd1);
    end
    repeat ($urandom_range(0, 2)) tick();
    cipherReady = 1'b1;
    tick();
    cipherReady = 1'b0;
    check("back_to_idle", {127'b0, startReady}, 128'd1);
  endtask

  initial begin
    reset = 1'b1; startValid = 1'b0; outReady = 1'b0; feedbackValid = 1'b0; cipherReady = 1'b0;
    plainText = '0; cipherKey = '0; feedbackState = '0;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] av, inv, b;
      av = 8'(a);
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        b = 8'(c);
        if (av != 8'h00 && gmul(av, b) == 8'h01) inv = b;
      end
      sboxT[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    tick();
    tick();
    check("reset_startReady", {127'b0, startReady}, 128'd1);
    check("reset_outValid", {127'b0, outValid}, 128'd0);
    check("reset_cipherValid", {127'b0, cipherValid}, 128'd0);
    check("reset_outState", outState, 128'd0);
    check("reset_roundNum", {124'b0, roundNum}, 128'd0);
    reset = 1'b0;

    runEnc(C1_PT, C1_KEY, -1, -1, 1'b0, 1'b1, C1_ROUND0, C1_CT);
    runEnc(C1_PT, C1_KEY, 3, -1, 1'b1, 1'b1, C1_ROUND0, C1_CT);
    runEnc(C1_PT, C1_KEY, -1, 4, 1'b0, 1'b1, C1_ROUND0, C1_CT);
    runEnc(C1_PT, C1_KEY, -1, -1, 1'b0, 1'b1, C1_ROUND0, C1_CT);
`ifdef AES_ROUND_KEY_EXPORT_EN
    runEnc({$urandom, $urandom, $urandom, $urandom}, APPX_KEY, -1, -1, 1'b0, 1'b0, '0, '0);
`endif
    for (int n = 0; n < 4; n++) begin
      runEnc({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(0, 12)), -1, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
    end
    repeat (3) tick();
    check("scoreboard_drained", 128'(sbQ.size()), 128'd0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
